// File: rtl/debug_halt_ctrl_pkg.sv
// Shared debug-mode definitions: dcsr.cause codes
// and the halt controller state type.
package debug_halt_ctrl_pkg;

  localparam logic [2:0] DCAUSE_EBREAK  = 3'd1;
  localparam logic [2:0] DCAUSE_HALTREQ = 3'd3;
  localparam logic [2:0] DCAUSE_STEP    = 3'd4;

  typedef enum logic [2:0] {
    RUNNING,
    DRAINING,
    HALTED,
    RESUMING,
    STEPPING
  } dbgstate_t;

endpackage

// File: rtl/debug_halt_ctrl_flopenr.sv
// Enabled flop with asynchronous active-high reset.
// Reset value is zero.
module flopenr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/debug_halt_ctrl.sv
// Debug halt/resume/step sequencer: drains M to a clean
// boundary, captures DPC/DCause, and redirects on resume.
module debug_halt_ctrl #(
  parameter int XLEN    = 64,
  parameter int CAUSE_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               HaltReq,
  input  logic               ResumeReq,
  input  logic               StepEn,
  input  logic               StepIE,
  input  logic               EbreakEn,
  input  logic               BreakpointFaultM,
  input  logic               InstrValidM,
  input  logic               StallM,
  input  logic               TrapM,
  input  logic               CommittedM,
  input  logic               CommittedF,
  input  logic [XLEN-1:0]    PCM,
  input  logic               DPCWriteEn,
  input  logic [XLEN-1:0]    DPCWriteVal,
  output logic               HaltFlushM,
  output logic               SuppressTrapM,
  output logic               IntMaskM,
  output logic               HaltStallF,
  output logic               DebugMode,
  output logic               ResumePCValid,
  output logic               ResumeAck,
  output logic [XLEN-1:0]    DPC,
  output logic [CAUSE_W-1:0] DCause
);

  import debug_halt_ctrl_pkg::*;

  dbgstate_t          state_q, state_d;
  logic [CAUSE_W-1:0] dcause_q, dcause_d;
  logic [XLEN-1:0]    dpc_d, dpc_q;
  logic               dpc_en;
  logic               bnd, ret, eb;

  assign ret = InstrValidM & ~StallM & ~TrapM;
  assign bnd = ret & ~CommittedM & ~CommittedF;

  assign eb = BreakpointFaultM & InstrValidM & EbreakEn &
              ((state_q == RUNNING)  |
               (state_q == DRAINING) |
               (state_q == STEPPING));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RUNNING;
      dcause_q <= '0;
    end else begin
      state_q  <= state_d;
      dcause_q <= dcause_d;
    end
  end

  flopenr #(.WIDTH(XLEN)) u_dpc (
    .clk   (clk),
    .reset (reset),
    .en    (dpc_en),
    .d     (dpc_d),
    .q     (dpc_q)
  );

  always_comb begin
    state_d       = state_q;
    dcause_d      = dcause_q;
    dpc_en        = 1'b0;
    dpc_d         = PCM;
    HaltFlushM    = 1'b0;
    SuppressTrapM = 1'b0;
    IntMaskM      = 1'b0;
    HaltStallF    = 1'b0;
    DebugMode     = 1'b0;
    ResumePCValid = 1'b0;
    ResumeAck     = 1'b0;

    case (state_q)
      RUNNING: begin
        if (HaltReq) begin
          state_d  = DRAINING;
          dcause_d = CAUSE_W'(DCAUSE_HALTREQ);
        end
      end
      DRAINING: begin
        IntMaskM = 1'b1;
        if (HaltReq) dcause_d = CAUSE_W'(DCAUSE_HALTREQ);
        // A trap is not a boundary; the halt lands on the handler.
        if (bnd) begin
          HaltFlushM = 1'b1;
          dpc_en     = 1'b1;
          state_d    = HALTED;
        end
      end
      HALTED: begin
        DebugMode  = 1'b1;
        HaltStallF = 1'b1;
        if (DPCWriteEn) begin
          dpc_en = 1'b1;
          dpc_d  = DPCWriteVal;
        end
        if (ResumeReq) state_d = RESUMING;
      end
      RESUMING: begin
        ResumePCValid = 1'b1;
        ResumeAck     = 1'b1;
        state_d       = StepEn ? STEPPING : RUNNING;
      end
      STEPPING: begin
        IntMaskM = ~StepIE;
        if (ret | TrapM) begin
          state_d  = DRAINING;
          dcause_d = HaltReq ? CAUSE_W'(DCAUSE_HALTREQ)
                             : CAUSE_W'(DCAUSE_STEP);
        end
      end
      default: state_d = RUNNING;
    endcase

    // Ebreak outranks every other reason to halt.
    if (eb) begin
      SuppressTrapM = 1'b1;
      HaltFlushM    = 1'b1;
      dpc_en        = 1'b1;
      dpc_d         = PCM;
      dcause_d      = CAUSE_W'(DCAUSE_EBREAK);
      state_d       = HALTED;
    end
  end

  assign DPC    = dpc_q;
  assign DCause = dcause_q;

endmodule

// File: tb/tb_debug_halt_ctrl.sv
// Directed bench for debug_halt_ctrl with a cycle model
// and literal checkpoints.
module tb_debug_halt_ctrl;

  localparam int XLEN = 64;
  localparam int CW   = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            HaltReq, ResumeReq, StepEn, StepIE, EbreakEn;
  logic            BreakpointFaultM, InstrValidM, StallM, TrapM;
  logic            CommittedM, CommittedF, DPCWriteEn;
  logic [XLEN-1:0] PCM, DPCWriteVal;
  logic            HaltFlushM, SuppressTrapM, IntMaskM, HaltStallF;
  logic            DebugMode, ResumePCValid, ResumeAck;
  logic [XLEN-1:0] DPC;
  logic [CW-1:0]   DCause;

  int n_cmp = 0;
  int n_bad = 0;

  debug_halt_ctrl #(.XLEN(XLEN), .CAUSE_W(CW)) dut (
    .clk              (clk),
    .reset            (reset),
    .HaltReq          (HaltReq),
    .ResumeReq        (ResumeReq),
    .StepEn           (StepEn),
    .StepIE           (StepIE),
    .EbreakEn         (EbreakEn),
    .BreakpointFaultM (BreakpointFaultM),
    .InstrValidM      (InstrValidM),
    .StallM           (StallM),
    .TrapM            (TrapM),
    .CommittedM       (CommittedM),
    .CommittedF       (CommittedF),
    .PCM              (PCM),
    .DPCWriteEn       (DPCWriteEn),
    .DPCWriteVal      (DPCWriteVal),
    .HaltFlushM       (HaltFlushM),
    .SuppressTrapM    (SuppressTrapM),
    .IntMaskM         (IntMaskM),
    .HaltStallF       (HaltStallF),
    .DebugMode        (DebugMode),
    .ResumePCValid    (ResumePCValid),
    .ResumeAck        (ResumeAck),
    .DPC              (DPC),
    .DCause           (DCause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // Model: halted / owes-a-halt / single-step armed / resume pulse.
  bit              m_halt, m_owe, m_step, m_res;
  logic [XLEN-1:0] m_dpc;
  logic [CW-1:0]   m_cause;
  bit              n_halt, n_owe, n_step, n_res;
  logic [XLEN-1:0] n_dpc;
  logic [CW-1:0]   n_cause;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_halt <= 0; m_owe <= 0; m_step <= 0; m_res <= 0;
      m_dpc <= '0; m_cause <= '0;
    end else begin
      m_halt <= n_halt; m_owe <= n_owe;
      m_step <= n_step; m_res <= n_res;
      m_dpc <= n_dpc; m_cause <= n_cause;
    end
  end

  always @(negedge clk) begin
    bit ret, bnd, eb;
    ret = InstrValidM & ~StallM & ~TrapM;
    bnd = ret & ~CommittedM & ~CommittedF;
    eb  = BreakpointFaultM & InstrValidM & EbreakEn & ~m_halt & ~m_res;
    if (reset) eb = 0;
    chk("m_flush", HaltFlushM, eb | (m_owe & bnd));
    chk("m_supp", SuppressTrapM, eb);
    chk("m_imask", IntMaskM, m_owe | (m_step & ~StepIE));
    chk("m_stallf", HaltStallF, m_halt);
    chk("m_dbg", DebugMode, m_halt);
    chk("m_rpv", ResumePCValid, m_res);
    chk("m_ack", ResumeAck, m_res);
    chk("m_dpc", DPC, m_dpc);
    chk("m_cause", DCause, m_cause);
    n_halt = m_halt; n_owe = m_owe; n_step = m_step; n_res = m_res;
    n_dpc = m_dpc; n_cause = m_cause;
    if (eb) begin
      n_halt = 1; n_owe = 0; n_step = 0; n_dpc = PCM; n_cause = 1;
    end else if (m_halt) begin
      if (DPCWriteEn) n_dpc = DPCWriteVal;
      if (ResumeReq) begin n_halt = 0; n_res = 1; end
    end else if (m_res) begin
      n_res = 0; n_step = StepEn;
    end else if (m_owe) begin
      if (HaltReq) n_cause = 3;
      if (bnd) begin n_halt = 1; n_owe = 0; n_dpc = PCM; end
    end else if (m_step) begin
      if (ret | TrapM) begin
        n_step = 0; n_owe = 1; n_cause = HaltReq ? 3 : 4;
      end
    end else if (HaltReq) begin
      n_owe = 1; n_cause = 3;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic idle();
    HaltReq = 0; ResumeReq = 0; BreakpointFaultM = 0;
    InstrValidM = 0; StallM = 0; TrapM = 0; CommittedM = 0;
    CommittedF = 0; DPCWriteEn = 0; DPCWriteVal = '0; PCM = '0;
  endtask

  task automatic resume();
    ResumeReq = 1; cyc(1); ResumeReq = 0; cyc(1);
  endtask

  initial begin
    reset = 1; StepEn = 0; StepIE = 0; EbreakEn = 0;
    idle();
    cyc(2);
    @(negedge clk);
    chk("rst_dbg", DebugMode, 0);
    chk("rst_dpc", DPC, 0);
    chk("rst_cause", DCause, 0);
    cyc(1); reset = 0; cyc(1);

    // halt from running
    HaltReq = 1; InstrValidM = 1; PCM = 64'h8000_0010;
    @(negedge clk); chk("hr_noflush0", HaltFlushM, 0);
    cyc(1);
    @(negedge clk); chk("hr_flush", HaltFlushM, 1);
    cyc(1); HaltReq = 0; InstrValidM = 0;
    @(negedge clk);
    chk("hr_dpc", DPC, 64'h8000_0010);
    chk("hr_cause", DCause, 3);
    chk("hr_dbg", DebugMode, 1);

    // resume with same-cycle DPC write
    ResumeReq = 1; DPCWriteEn = 1; DPCWriteVal = 64'h8000_0200;
    cyc(1); ResumeReq = 0; DPCWriteEn = 0;
    @(negedge clk);
    chk("rs_rpv", ResumePCValid, 1);
    chk("rs_ack", ResumeAck, 1);
    chk("rs_dpc", DPC, 64'h8000_0200);
    chk("rs_stallf", HaltStallF, 0);
    cyc(1);
    @(negedge clk); chk("rs_run", DebugMode, 0);
    ResumeReq = 1;
    @(negedge clk); chk("rs_noack", ResumeAck, 0);
    cyc(1);
    @(negedge clk); chk("rs_noack2", ResumeAck, 0);
    ResumeReq = 0;

    // drain stalled by a committed bus transaction
    HaltReq = 1; InstrValidM = 1; CommittedM = 1; PCM = 64'h8000_0030;
    cyc(1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("dr_noflush", HaltFlushM, 0);
      chk("dr_imask", IntMaskM, 1);
      cyc(1);
    end
    CommittedM = 0; PCM = 64'h8000_0040;
    @(negedge clk); chk("dr_flush", HaltFlushM, 1);
    cyc(1); HaltReq = 0;
    @(negedge clk); chk("dr_dpc", DPC, 64'h8000_0040);
    resume();

    // trap mid-drain halts on the handler
    HaltReq = 1; CommittedM = 1; PCM = 64'h8000_0050;
    cyc(1); TrapM = 1; CommittedM = 0;
    @(negedge clk); chk("tr_noflush", HaltFlushM, 0);
    cyc(1); TrapM = 0; PCM = 64'h8000_0800;
    @(negedge clk); chk("tr_flush", HaltFlushM, 1);
    cyc(1); HaltReq = 0;
    @(negedge clk);
    chk("tr_dpc", DPC, 64'h8000_0800);
    chk("tr_cause", DCause, 3);
    resume();

    // ebreak entry
    EbreakEn = 1; BreakpointFaultM = 1; PCM = 64'h8000_0100;
    @(negedge clk);
    chk("eb_supp", SuppressTrapM, 1);
    chk("eb_flush", HaltFlushM, 1);
    cyc(1); BreakpointFaultM = 0;
    @(negedge clk);
    chk("eb_dbg", DebugMode, 1);
    chk("eb_cause", DCause, 1);
    chk("eb_dpc", DPC, 64'h8000_0100);
    InstrValidM = 0; resume();
    EbreakEn = 0; BreakpointFaultM = 1; InstrValidM = 1; TrapM = 1;
    @(negedge clk);
    chk("ebo_supp", SuppressTrapM, 0);
    chk("ebo_flush", HaltFlushM, 0);
    cyc(1); BreakpointFaultM = 0; TrapM = 0;
    @(negedge clk); chk("ebo_dbg", DebugMode, 0);

    // get halted, then single-step
    EbreakEn = 1; BreakpointFaultM = 1; PCM = 64'h8000_0180;
    cyc(1); BreakpointFaultM = 0; InstrValidM = 0;
    StepEn = 1; StepIE = 0;
    ResumeReq = 1; DPCWriteEn = 1; DPCWriteVal = 64'h8000_0200;
    cyc(1); ResumeReq = 0; DPCWriteEn = 0;
    cyc(1);
    @(negedge clk); chk("st_imask", IntMaskM, 1);
    InstrValidM = 1; PCM = 64'h8000_0200;
    cyc(1); PCM = 64'h8000_0204;
    @(negedge clk); chk("st_flush", HaltFlushM, 1);
    cyc(1); InstrValidM = 0;
    @(negedge clk);
    chk("st_dbg", DebugMode, 1);
    chk("st_dpc", DPC, 64'h8000_0204);
    chk("st_cause", DCause, 4);

    // step interrupted by haltreq
    StepIE = 1; resume();
    @(negedge clk); chk("sh_imask", IntMaskM, 0);
    HaltReq = 1; InstrValidM = 1; PCM = 64'h8000_0204;
    cyc(1); PCM = 64'h8000_0208;
    cyc(1); HaltReq = 0; InstrValidM = 0; StepEn = 0;
    @(negedge clk);
    chk("sh_dpc", DPC, 64'h8000_0208);
    chk("sh_cause", DCause, 3);

    // reset while halted
    reset = 1; #1;
    chk("rh_dbg", DebugMode, 0);
    chk("rh_dpc", DPC, 0);
    chk("rh_cause", DCause, 0);
    cyc(1); reset = 0; cyc(1);

    // reset while draining
    HaltReq = 1; InstrValidM = 1; CommittedM = 1; PCM = 64'h8000_0300;
    cyc(1);
    @(negedge clk); chk("rd_imask1", IntMaskM, 1);
    cyc(1); reset = 1; #1;
    chk("rd_imask0", IntMaskM, 0);
    chk("rd_cause", DCause, 0);
    chk("rd_dpc", DPC, 0);
    idle(); cyc(1); reset = 0; cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
